// File: rtl/nonrestoring_divider_seq.sv
// Sequential signed radix-2 non-restoring divider: serial operands in, quotient then remainder out.
// Fixed latency for every operand pair, including divide-by-zero and overflow.
module nonrestoring_divider_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             begin_op,
  input  logic [WIDTH-1:0] inbus,
  output logic [WIDTH-1:0] outbus,
  output logic             out_valid,
  output logic             end_op,
  output logic             busy,
  output logic             div_by_zero,
  output logic             overflow
);

  // Partial remainder carries two extra bits so that 2*P +/- D never wraps, even for D = 2^(WIDTH-1).
  localparam int unsigned PW = WIDTH + 2;

  localparam logic [WIDTH-1:0] One     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadDiv,
    StDivide,
    StCorrect,
    StSignFix,
    StOutQ,
    StOutR
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             quot_neg_q, quot_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] outbus_q, outbus_d;
  logic             out_valid_q, out_valid_d;
  logic             end_op_q, end_op_d;
  logic             busy_q, busy_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [PW-1:0]    d_ext;
  logic [PW-1:0]    p_shift;
  logic [PW-1:0]    p_step;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    // Magnitude as unsigned: the most negative value maps onto itself, which reads as 2^(WIDTH-1).
    return v[WIDTH-1] ? (~v + One) : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + One) : v;
  endfunction

  assign d_ext   = {2'b00, d_q};
  assign p_shift = {p_q[PW-2:0], q_q[WIDTH-1]};
  assign p_step  = p_q[PW-1] ? (p_shift + d_ext) : (p_shift - d_ext);

  // Signed result, with the two exceptional operand pairs overriding the datapath.
  always_comb begin
    quot_fix = neg_if(q_q, quot_neg_q);
    rem_fix  = neg_if(p_q[WIDTH-1:0], rem_neg_q);
    if (dvs_q == '0) begin
      quot_fix = AllOnes;
      rem_fix  = dvd_q;
    end else if ((dvd_q == MinNeg) && (dvs_q == AllOnes)) begin
      quot_fix = MinNeg;
      rem_fix  = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quot_neg_d  = quot_neg_q;
    rem_neg_d   = rem_neg_q;
    p_d         = p_q;
    q_d         = q_q;
    d_d         = d_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    outbus_d    = '0;
    out_valid_d = 1'b0;
    end_op_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (begin_op) begin
          dvd_d   = inbus;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = StLoadDiv;
        end
      end
      StLoadDiv: begin
        dvs_d      = inbus;
        quot_neg_d = dvd_q[WIDTH-1] ^ inbus[WIDTH-1];
        rem_neg_d  = dvd_q[WIDTH-1];
        q_d        = abs_val(dvd_q);
        d_d        = abs_val(inbus);
        p_d        = '0;
        state_d    = StDivide;
      end
      StDivide: begin
        p_d   = p_step;
        q_d   = {q_q[WIDTH-2:0], ~p_step[PW-1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StCorrect;
        end
      end
      StCorrect: begin
        if (p_q[PW-1]) begin
          p_d = p_q + d_ext;
        end
        state_d = StSignFix;
      end
      StSignFix: begin
        // Park the final remainder in P so the remainder beat is a plain register read.
        q_d         = quot_fix;
        p_d         = {2'b00, rem_fix};
        dbz_d       = (dvs_q == '0);
        ovf_d       = (dvs_q != '0) && (dvd_q == MinNeg) && (dvs_q == AllOnes);
        outbus_d    = quot_fix;
        out_valid_d = 1'b1;
        state_d     = StOutQ;
      end
      StOutQ: begin
        outbus_d    = p_q[WIDTH-1:0];
        out_valid_d = 1'b1;
        end_op_d    = 1'b1;
        state_d     = StOutR;
      end
      StOutR: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quot_neg_q  <= 1'b0;
      rem_neg_q   <= 1'b0;
      p_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      outbus_q    <= '0;
      out_valid_q <= 1'b0;
      end_op_q    <= 1'b0;
      busy_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quot_neg_q  <= quot_neg_d;
      rem_neg_q   <= rem_neg_d;
      p_q         <= p_d;
      q_q         <= q_d;
      d_q         <= d_d;
      outbus_q    <= outbus_d;
      out_valid_q <= out_valid_d;
      end_op_q    <= end_op_d;
      busy_q      <= busy_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign outbus      = outbus_q;
  assign out_valid   = out_valid_q;
  assign end_op      = end_op_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_nonrestoring_divider_seq.sv
// Directed, table-driven bench for the signed sequential divider: results, flags, latency,
// ignored begin_op while busy and reset during an operation.
module tb_nonrestoring_divider_seq;

  logic       clk;
  logic       rst_b;
  logic       begin_op;
  logic [7:0] inbus;
  logic [7:0] outbus;
  logic       out_valid;
  logic       end_op;
  logic       busy;
  logic       div_by_zero;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
  } vec_t;

  localparam int NVec = 17;
  vec_t vecs[NVec];

  nonrestoring_divider_seq #(
    .WIDTH(8),
    .CNT_W(3)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .begin_op   (begin_op),
    .inbus      (inbus),
    .outbus     (outbus),
    .out_valid  (out_valid),
    .end_op     (end_op),
    .busy       (busy),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " outbus"}, outbus, 0);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " end_op"}, end_op, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " div_by_zero"}, div_by_zero, 0);
    check({tag, " overflow"}, overflow, 0);
  endtask

  // One complete operation; quotient must appear 11 edges after the accepting edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                        input logic [7:0] er, input logic edbz, input logic eovf,
                        input bit poke, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    begin_op = 1'b1;
    inbus    = a;
    @(posedge clk);
    #1;
    check({tag, " busy after start"}, busy, 1);
    check({tag, " dbz cleared"}, div_by_zero, 0);
    check({tag, " ovf cleared"}, overflow, 0);
    begin_op = 1'b0;
    inbus    = b;
    @(posedge clk);
    #1;
    inbus = 8'h5A;
    lat   = 1;
    seen  = 1'b0;
    while (!seen && lat < 30) begin
      begin_op = poke && (lat >= 2) && (lat <= 8);
      if (begin_op) inbus = 8'($urandom);
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) seen = 1'b1;
      else if (busy !== 1'b1) begin
        check({tag, " busy held"}, busy, 1);
      end
    end
    begin_op = 1'b0;
    check({tag, " latency"}, lat, 11);
    check({tag, " quotient"}, outbus, eq);
    check({tag, " end_op on q beat"}, end_op, 0);
    check({tag, " dbz on q beat"}, div_by_zero, edbz);
    check({tag, " ovf on q beat"}, overflow, eovf);
    @(posedge clk);
    #1;
    check({tag, " remainder"}, outbus, er);
    check({tag, " valid on r beat"}, out_valid, 1);
    check({tag, " end_op on r beat"}, end_op, 1);
    check({tag, " busy on r beat"}, busy, 1);
    @(posedge clk);
    #1;
    check({tag, " valid idle"}, out_valid, 0);
    check({tag, " end_op idle"}, end_op, 0);
    check({tag, " busy idle"}, busy, 0);
    check({tag, " outbus idle"}, outbus, 0);
    check({tag, " dbz held"}, div_by_zero, edbz);
    check({tag, " ovf held"}, overflow, eovf);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0};  // 100 / 7
    vecs[1]  = '{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0};  // -100 / 7
    vecs[2]  = '{8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0};  // 100 / -7
    vecs[3]  = '{8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0};  // -100 / -7
    vecs[4]  = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1};  // -128 / -1
    vecs[5]  = '{8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0};  // -128 / 1
    vecs[6]  = '{8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1'b0};  // 5 / 0
    vecs[7]  = '{8'h00, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0};  // 0 / 5
    vecs[8]  = '{8'h07, 8'h64, 8'h00, 8'h07, 1'b0, 1'b0};  // 7 / 100
    vecs[9]  = '{8'hF9, 8'h64, 8'h00, 8'hF9, 1'b0, 1'b0};  // -7 / 100
    vecs[10] = '{8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0};  // 127 / -128
    vecs[11] = '{8'h80, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0};  // -128 / -128
    vecs[12] = '{8'h80, 8'h7F, 8'hFF, 8'hFF, 1'b0, 1'b0};  // -128 / 127
    vecs[13] = '{8'h00, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0};  // 0 / 0
    vecs[14] = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0};  // -1 / 0
    vecs[15] = '{8'h80, 8'h02, 8'hC0, 8'h00, 1'b0, 1'b0};  // -128 / 2
    vecs[16] = '{8'h7F, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b0};  // 127 / 1

    rst_b    = 1'b1;
    begin_op = 1'b0;
    inbus    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_b = 1'b0;

    for (int i = 0; i < NVec; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf, 1'b0,
             $sformatf("vec%0d", i));
    end

    // begin_op pulsed with junk operands while dividing must not disturb 100 / 7.
    run_op(8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b1, "poke");

    // Reset in the middle of DIVIDE, then a fresh operation.
    @(negedge clk);
    begin_op = 1'b1;
    inbus    = 8'h64;
    @(negedge clk);
    begin_op = 1'b0;
    inbus    = 8'h07;
    repeat (4) @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_b = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        check("midreset stays idle", {out_valid, busy}, 0);
      end
    end
    run_op(8'h7F, 8'h0A, 8'h0C, 8'h07, 1'b0, 1'b0, 1'b0, "after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
